// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : EX-stage iterative multiply/divide unit with its HI/LO pair.
//               MULT/MULTU use shift-add and DIV/DIVU use restoring division.
//               Both take 32 cycles. MFHI/MFLO/MTHI/MTLO are also handled
//               here, and the unit stalls the front end while a result is
//               pending.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        kill,
    output logic        busy,
    output logic        stall,
    output logic [31:0] mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] c_MFHI  = 6'h10;
    localparam logic [5:0] c_MTHI  = 6'h11;
    localparam logic [5:0] c_MFLO  = 6'h12;
    localparam logic [5:0] c_MTLO  = 6'h13;
    localparam logic [5:0] c_MULT  = 6'h18;
    localparam logic [5:0] c_MULTU = 6'h19;
    localparam logic [5:0] c_DIV   = 6'h1A;
    localparam logic [5:0] c_DIVU  = 6'h1B;

    // Architectural and iteration state
    logic        busy_q,  busy_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q,   acc_d;    // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] dvsr_q,  dvsr_d;   // mul: multiplicand magnitude; div: divisor magnitude
    logic        is_div_q, is_div_d;
    logic        neg_q,   neg_d;    // negate product / quotient at completion
    logic        rneg_q,  rneg_d;   // negate remainder at completion
    logic        div0_q,  div0_d;   // divisor was zero
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    // Decode
    logic        w_is_mul, w_is_div, w_is_md, w_is_known, w_signed, w_accept;
    logic [31:0] w_abs_a, w_abs_b;

    assign w_is_mul   = (funct == c_MULT) || (funct == c_MULTU);
    assign w_is_div   = (funct == c_DIV)  || (funct == c_DIVU);
    assign w_is_md    = w_is_mul || w_is_div;
    assign w_is_known = w_is_md || (funct == c_MFHI) || (funct == c_MFLO) ||
                        (funct == c_MTHI) || (funct == c_MTLO);
    // Signed variants have an even funct code
    assign w_signed   = ~funct[0];
    assign w_accept   = issue_valid && !busy_q && !kill && w_is_md;
    assign w_abs_a    = (w_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
    assign w_abs_b    = (w_signed && op_b[31]) ? (32'd0 - op_b) : op_b;

    // One iteration step of either algorithm
    logic [32:0] w_sum;
    logic [32:0] w_rs;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_step;

    assign w_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvsr_q} : 33'd0);
    assign w_rs   = {acc_q[63:32], acc_q[31]};
    assign w_ge   = (w_rs >= {1'b0, dvsr_q});
    // True difference is below 2^32 whenever w_ge holds, so 32 bits suffice
    assign w_diff = w_rs[31:0] - dvsr_q;

    // Select the next accumulator value for the operation in flight
    always_comb begin
        w_step = acc_q;
        if (is_div_q) begin
            w_step = w_ge ? {w_diff, acc_q[30:0], 1'b1}
                          : {w_rs[31:0], acc_q[30:0], 1'b0};
        end else begin
            w_step = {w_sum, acc_q[31:1]};
        end
    end

    // Sign/zero correction applied on the final step
    logic [63:0] w_prod;
    logic [31:0] w_quot, w_rem;

    assign w_prod = neg_q ? (64'd0 - w_step) : w_step;
    assign w_quot = div0_q ? DIV_ZERO_Q : (neg_q  ? (32'd0 - w_step[31:0])  : w_step[31:0]);
    assign w_rem  = rneg_q ? (32'd0 - w_step[63:32]) : w_step[63:32];

    // Next-state: kill, iteration/completion, accept, and MTHI/MTLO writes
    always_comb begin
        busy_d   = busy_q;
        count_d  = count_q;
        acc_d    = acc_q;
        dvsr_d   = dvsr_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (kill) begin
            busy_d  = 1'b0;
            count_d = 5'd0;
        end else if (busy_q) begin
            acc_d   = w_step;
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) begin
                busy_d  = 1'b0;
                count_d = 5'd0;
                if (is_div_q) begin
                    hi_d = w_rem;
                    lo_d = w_quot;
                end else begin
                    hi_d = w_prod[63:32];
                    lo_d = w_prod[31:0];
                end
            end
        end else if (w_accept) begin
            busy_d   = 1'b1;
            count_d  = 5'd0;
            is_div_d = w_is_div;
            div0_d   = w_is_div && (op_b == 32'd0);
            if (w_is_div && (op_b == 32'd0)) begin
                // Raw dividend passes through unchanged as the remainder
                acc_d  = {32'd0, op_a};
                dvsr_d = 32'd0;
                neg_d  = 1'b0;
                rneg_d = 1'b0;
            end else if (w_is_div) begin
                acc_d  = {32'd0, w_abs_a};
                dvsr_d = w_abs_b;
                neg_d  = w_signed && (op_a[31] ^ op_b[31]);
                rneg_d = w_signed && op_a[31];
            end else begin
                acc_d  = {32'd0, w_abs_b};
                dvsr_d = w_abs_a;
                neg_d  = w_signed && (op_a[31] ^ op_b[31]);
                rneg_d = 1'b0;
            end
        end else if (issue_valid) begin
            if (funct == c_MTHI) hi_d = op_a;
            if (funct == c_MTLO) lo_d = op_a;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            count_q  <= 5'd0;
            acc_q    <= 64'd0;
            dvsr_q   <= 32'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            busy_q   <= busy_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            dvsr_q   <= dvsr_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Outputs: pipeline hold and move-from data path
    always_comb begin
        stall   = issue_valid && busy_q && w_is_known;
        mf_data = 32'd0;
        if (issue_valid && (funct == c_MFHI)) mf_data = hi_q;
        if (issue_valid && (funct == c_MFLO)) mf_data = lo_q;
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Self-checking bench for ex_muldiv with an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

    localparam logic [5:0] MFHI  = 6'h10;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MFLO  = 6'h12;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;
    localparam logic [31:0] DZQ  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b;
    logic        kill;
    logic        busy, stall;
    logic [31:0] mf_data, hi, lo;

    int checks = 0;
    int errors = 0;
    int n, st;
    logic [31:0] exp_hi, exp_lo;

    ex_muldiv #(.DIV_ZERO_Q(DZQ)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .funct(funct),
        .op_a(op_a), .op_b(op_b), .kill(kill), .busy(busy), .stall(stall),
        .mf_data(mf_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {HI,LO} from plain integer arithmetic
    function automatic logic [63:0] ref_res(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] pu;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                return pu;
            end
            MULT: begin
                p = sa * sb;
                return 64'(p);
            end
            DIVU: begin
                if (b == 32'd0) return {a, DZQ};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, DZQ};
                q = sa / sb;
                r = sa % sb;
                qv = 64'(q);
                rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    // Issue one mul/div, wait for completion, check latency and result
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        issue_valid = 1'b1; funct = f; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0; funct = 6'h00;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk); #1;
        end
        {exp_hi, exp_lo} = ref_res(f, a, b);
        chk("busy_cycles", 64'(n), 64'd32);
        chk("hi", {32'd0, hi}, {32'd0, exp_hi});
        chk("lo", {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        logic [5:0]  rf;
        logic [31:0] ra, rb;
        reset = 1'b1; issue_valid = 1'b0; funct = 6'h00; op_a = '0; op_b = '0; kill = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);

        // Directed arithmetic cases
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_spec", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(MULT,  32'hFFFF_FFFD, 32'h0000_0005);
        chk("mult_neg_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(DIV,   32'hFFFF_FFF9, 32'h0000_0002);
        chk("div_neg_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(DIVU,  32'h0000_0007, 32'h0000_0000);
        chk("divu_zero_spec", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_spec", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(DIV,   32'hFFFF_FFF0, 32'h0000_0000);

        // MFLO presented behind DIVU 100/7
        @(negedge clk);
        issue_valid = 1'b1; funct = DIVU; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0; funct = 6'h00;
        @(negedge clk);
        issue_valid = 1'b1; funct = MFLO;
        #1;
        n = 0; st = 0;
        while (busy === 1'b1 && n < 100) begin
            if (stall === 1'b1) st++;
            n++;
            @(negedge clk); #1;
        end
        chk("mflo_stall_cycles", 64'(st), 64'd31);
        chk("mflo_stall_released", {63'd0, stall}, 64'd0);
        chk("mflo_data", {32'd0, mf_data}, 64'h0000_000E);
        funct = MFHI; #1;
        chk("mfhi_data", {32'd0, mf_data}, 64'h0000_0002);
        funct = 6'h20; #1;
        chk("mf_other_funct", {32'd0, mf_data}, 64'd0);
        chk("stall_idle", {63'd0, stall}, 64'd0);
        exp_hi = 32'd2; exp_lo = 32'd14;

        // Back-to-back: MULT held while DIV runs
        @(negedge clk);
        issue_valid = 1'b1; funct = DIV; op_a = 32'hFFFF_FF9C; op_b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        funct = MULT; op_a = 32'h0001_2345; op_b = 32'hFFFF_0000;
        #1;
        chk("b2b_stall", {63'd0, stall}, 64'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk); #1;
        end
        chk("b2b_first_cycles", 64'(n), 64'd32);
        chk("b2b_no_stall", {63'd0, stall}, 64'd0);
        chk("b2b_div_res", {hi, lo}, ref_res(DIV, 32'hFFFF_FF9C, 32'd9));
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0; funct = 6'h00;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk); #1;
        end
        chk("b2b_second_cycles", 64'(n), 64'd32);
        {exp_hi, exp_lo} = ref_res(MULT, 32'h0001_2345, 32'hFFFF_0000);
        chk("b2b_mult_res", {hi, lo}, {exp_hi, exp_lo});

        // MTHI then MULTU killed at iteration 10
        @(negedge clk);
        issue_valid = 1'b1; funct = MTHI; op_a = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0; funct = 6'h00;
        #1;
        exp_hi = 32'h1234_5678;
        chk("mthi_hi", {32'd0, hi}, {32'd0, exp_hi});
        chk("mthi_lo_kept", {32'd0, lo}, {32'd0, exp_lo});
        @(negedge clk);
        issue_valid = 1'b1; funct = MULTU; op_a = 32'd2; op_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0; funct = 6'h00;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        #1;
        chk("kill_busy", {63'd0, busy}, 64'd0);
        chk("kill_hi", {32'd0, hi}, {32'd0, exp_hi});
        chk("kill_lo", {32'd0, lo}, {32'd0, exp_lo});
        repeat (40) @(negedge clk);
        #1;
        chk("kill_hilo_later", {hi, lo}, {exp_hi, exp_lo});

        // Same, aborted by asynchronous reset
        @(negedge clk);
        issue_valid = 1'b1; funct = MULTU; op_a = 32'd2; op_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0; funct = 6'h00;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        exp_hi = 32'd0; exp_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("rst_hilo_later", {hi, lo}, 64'd0);

        // MTLO coinciding with kill is dropped; plain MTLO lands
        @(negedge clk);
        issue_valid = 1'b1; funct = MTLO; op_a = 32'hDEAD_BEEF; kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0; issue_valid = 1'b0;
        #1;
        chk("mtlo_killed", {hi, lo}, {exp_hi, exp_lo});
        @(negedge clk);
        issue_valid = 1'b1; funct = MTLO; op_a = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0; funct = 6'h00;
        #1;
        exp_lo = 32'hDEAD_BEEF;
        chk("mtlo_lo", {hi, lo}, {exp_hi, exp_lo});

        // Randomized mul/div operations
        for (int i = 0; i < 24; i++) begin
            rf = 6'h18 + 6'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'd0 - 32'($urandom_range(1, 1000));
                default: rb = $urandom;
            endcase
            run_op(rf, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit with its HI/LO register pair, sitting in the EX stage directly downstream of the ID/EX pipeline register.
- Consumes the forwarded operand buses and the instruction funct field for the R-type instruction currently in EX.
- Executes MULT/MULTU/DIV/DIVU over 32 cycles and services MFHI/MFLO/MTHI/MTLO.
- Raises a stall to freeze PC, IF/ID and ID/EX while a result is pending.

Parameters:
- DIV_ZERO_Q, 32'hFFFF_FFFF, LO value written when the divisor is zero.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- issue_valid  in  1  EX holds a live (not flushed) R-type instruction.
- funct  in  6  instruction bits [5:0] of the EX instruction.
- op_a  in  32  forwarded rs value.
- op_b  in  32  forwarded rt value.
- kill  in  1  synchronous abort of any in-progress operation (exception/flush).
- busy  out  1  iterative operation in progress.
- stall  out  1  hold the pipeline; the EX instruction must be re-presented next cycle.
- mf_data  out  32  HI (MFHI) or LO (MFLO) for writeback; 0 for other functs.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, iteration count=0, internal shift registers=0. Reset mid-operation discards the operation.
- Decode, only when issue_valid=1:
  - 6'h18 MULT, 6'h19 MULTU, 6'h1A DIV, 6'h1B DIVU.
  - 6'h10 MFHI, 6'h12 MFLO, 6'h11 MTHI, 6'h13 MTLO.
  - Any other funct: the unit does nothing.
- stall = issue_valid & busy & (funct is any of the 8 above). stall is combinational; it is 0 when busy=0.
- Accept: at a rising edge with issue_valid & !busy & !kill & mul/div funct:
  - Latch the operands; signed ops store absolute values plus result-sign flags.
  - count<=0, busy<=1.
- Iterate, one step per edge while busy:
  - Multiply: shift-add, 1 multiplier bit per cycle, 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
- Completion: on the edge where busy=1 and count==31:
  - Write the result to HI/LO and set busy<=0. busy is therefore high for exactly 32 cycles.
  - New HI/LO are visible in the first cycle busy=0.
  - A stalled instruction proceeds in that same cycle.
- Multiply result: {HI,LO} = 64-bit product.
  - MULT: if the operand signs differ, the 64-bit magnitude is two's-complement negated.
- Divide result: LO = quotient, HI = remainder.
  - DIV: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (DIV or DIVU): LO=DIV_ZERO_Q, HI=raw op_a. No sign correction; still takes 32 cycles.
- MTHI/MTLO: at the edge with issue_valid & !busy & !kill, hi<=op_a (or lo<=op_a). The other register is unchanged.
- MFHI/MFLO: mf_data = hi or lo combinationally. Only meaningful when stall=0.
- kill:
  - Busy, or coinciding with an accept/MT edge: busy<=0, count<=0, HI/LO unchanged, no new accept.
  - Idle: no effect.
- Back-to-back issue: a mul/div presented while busy stalls and is accepted on the first non-busy edge.

Test Plan:
- MULTU op_a=FFFFFFFF, op_b=FFFFFFFF -> busy high 32 cycles, then HI=FFFFFFFE, LO=00000001.
- MULT op_a=FFFFFFFD (-3), op_b=00000005 -> HI=FFFFFFFF, LO=FFFFFFF1.
- DIV op_a=FFFFFFF9 (-7), op_b=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU 7/0 -> LO=FFFFFFFF, HI=00000007.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=80000000, HI=00000000.
- MFLO issued 1 cycle after DIVU 100/7 -> stall=1 for the remaining 31 busy cycles, then stall=0 and mf_data=0000000E; MFHI then gives 00000002.
- MTHI 0x12345678 then MULTU 2*3; assert kill at iteration 10 -> busy=0 next cycle, HI=12345678, LO unchanged. Repeat with async reset at iteration 10 -> HI=LO=0, busy=0.
